// File: rtl/keypad_scanner_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Column strobes are active-low one-hot; key codes are row_idx*4 + col_idx.
package keypad_scanner_pkg;

    localparam int KEY_W = 4;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_t;

    localparam logic [3:0] COL0 = 4'b1110;
    localparam logic [3:0] COL1 = 4'b1101;
    localparam logic [3:0] COL2 = 4'b1011;
    localparam logic [3:0] COL3 = 4'b0111;

    function automatic logic [3:0] col_pattern(input logic [1:0] idx);
        case (idx)
            2'd0:    return COL0;
            2'd1:    return COL1;
            2'd2:    return COL2;
            default: return COL3;
        endcase
    endfunction

    // Lowest-index low row wins; only meaningful when at least one row is low.
    function automatic logic [1:0] first_low(input logic [3:0] rows);
        if (!rows[0])      return 2'd0;
        else if (!rows[1]) return 2'd1;
        else if (!rows[2]) return 2'd2;
        else               return 2'd3;
    endfunction

endpackage

// File: rtl/keypad_scanner_tick.sv
// Single-clock tick pulse every DIV clocks; first tick DIV clocks after reset.
// Also usable as the refresh strobe of the FND multiplex driver.
module scan_tick_gen #(
    parameter int DIV = 100_000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int            CW   = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates column strobes, debounces a press and its
// release, and reports the accepted key with a one-clock valid pulse.
module keypad_scanner
    import keypad_scanner_pkg::*;
#(
    parameter int SCAN_DIV  = 100_000,
    parameter int DEB_TICKS = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       row,
    output logic [3:0]       col,
    output logic [KEY_W-1:0] key_code,
    output logic             key_valid,
    output logic             key_pressed
);

    localparam int               CNT_W   = $clog2(DEB_TICKS + 1);
    localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEB_TICKS);

    logic             tick;
    logic [3:0]       row_s1, row_s2;
    state_t           state, state_n;
    logic [1:0]       col_idx, col_idx_n;
    logic [1:0]       row_idx, row_idx_n;
    logic [CNT_W-1:0] deb_cnt, deb_cnt_n, deb_sat;
    logic [CNT_W-1:0] rel_cnt, rel_cnt_n, rel_sat;
    logic [KEY_W-1:0] key_code_n;
    logic             key_valid_n, key_pressed_n;
    logic             latched_low;

    scan_tick_gen #(.DIV(SCAN_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_s1 <= 4'b1111;
            row_s2 <= 4'b1111;
        end else begin
            row_s1 <= row;
            row_s2 <= row_s1;
        end
    end

    assign latched_low = !row_s2[row_idx];
    assign deb_sat     = (deb_cnt == DEB_MAX) ? deb_cnt : deb_cnt + CNT_W'(1);
    assign rel_sat     = (rel_cnt == DEB_MAX) ? rel_cnt : rel_cnt + CNT_W'(1);

    always_comb begin
        state_n       = state;
        col_idx_n     = col_idx;
        row_idx_n     = row_idx;
        deb_cnt_n     = deb_cnt;
        rel_cnt_n     = rel_cnt;
        key_code_n    = key_code;
        key_valid_n   = 1'b0;
        key_pressed_n = key_pressed;
        case (state)
            SCAN: begin
                if (tick) begin
                    if (&row_s2) begin
                        col_idx_n = col_idx + 2'd1;
                    end else begin
                        row_idx_n = first_low(row_s2);
                        deb_cnt_n = '0;
                        state_n   = DEBOUNCE;
                    end
                end
            end
            DEBOUNCE: begin
                if (tick) begin
                    if (latched_low) begin
                        deb_cnt_n = deb_sat;
                        if (deb_sat == DEB_MAX) begin
                            key_code_n    = {row_idx, col_idx};
                            key_valid_n   = 1'b1;
                            key_pressed_n = 1'b1;
                            rel_cnt_n     = '0;
                            state_n       = HELD;
                        end
                    end else begin
                        col_idx_n = col_idx + 2'd1;
                        state_n   = SCAN;
                    end
                end
            end
            HELD: begin
                // Column stays parked on the held key; other rows are ignored.
                if (tick) begin
                    if (latched_low) begin
                        rel_cnt_n = '0;
                    end else begin
                        rel_cnt_n = rel_sat;
                        if (rel_sat == DEB_MAX) begin
                            key_pressed_n = 1'b0;
                            col_idx_n     = col_idx + 2'd1;
                            state_n       = SCAN;
                        end
                    end
                end
            end
            default: state_n = SCAN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= SCAN;
            col_idx     <= 2'd0;
            col         <= COL0;
            row_idx     <= 2'd0;
            deb_cnt     <= '0;
            rel_cnt     <= '0;
            key_code    <= '0;
            key_valid   <= 1'b0;
            key_pressed <= 1'b0;
        end else begin
            state       <= state_n;
            col_idx     <= col_idx_n;
            col         <= col_pattern(col_idx_n);
            row_idx     <= row_idx_n;
            deb_cnt     <= deb_cnt_n;
            rel_cnt     <= rel_cnt_n;
            key_code    <= key_code_n;
            key_valid   <= key_valid_n;
            key_pressed <= key_pressed_n;
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner (SCAN_DIV=4, DEB_TICKS=3) with a keypad matrix model.
// Timing is tracked as clock edges e counted from reset release; ticks land on e%4==0.
module tb_keypad_scanner;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  row = 4'b1111;
    logic [3:0]  col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_pressed;

    logic [15:0] keys = 16'h0000;
    logic [3:0]  pat [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    int          e = 0;
    int          vcnt = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    keypad_scanner #(.SCAN_DIV(4), .DEB_TICKS(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .row         (row),
        .col         (col),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_pressed (key_pressed)
    );

    always #5 clk = ~clk;

    // A pressed key (r,c) pulls row r low while column c is strobed.
    function automatic logic [3:0] kp_rows(input logic [3:0] c, input logic [15:0] k);
        logic [3:0] r;
        r = 4'b1111;
        for (int rr = 0; rr < 4; rr++)
            for (int cc = 0; cc < 4; cc++)
                if (k[rr*4+cc] && c[cc] === 1'b0) r[rr] = 1'b0;
        return r;
    endfunction

    task automatic cyc();
        @(posedge clk);
        e++;
        #1;
        row = kp_rows(col, keys);
        if (key_valid === 1'b1) vcnt++;
    endtask

    task automatic run_to(input int t);
        while (e < t) cyc();
    endtask

    task automatic set_keys(input logic [15:0] k);
        keys = k;
        row  = kp_rows(col, keys);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        e     = 0;
        vcnt  = 0;
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (col !== 4'b1110) begin n_err++; $display("FAIL reset_col: got %b want 1110", col); end
        n_cmp++; if (key_code !== 4'd0) begin n_err++; $display("FAIL reset_code: got %0d want 0", key_code); end
        n_cmp++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", key_valid); end
        n_cmp++; if (key_pressed !== 1'b0) begin n_err++; $display("FAIL reset_pressed: got %b want 0", key_pressed); end
        repeat (3) @(posedge clk);
        release_reset();
    endtask

    task automatic test_idle_scan();
        for (int k = 1; k <= 8; k++) begin
            run_to(4*k - 1);
            n_cmp++; if (col !== pat[(k-1)%4]) begin n_err++; $display("FAIL idle_col_hold e=%0d: got %b want %b", e, col, pat[(k-1)%4]); end
            run_to(4*k);
            n_cmp++; if (col !== pat[k%4]) begin n_err++; $display("FAIL idle_col_step e=%0d: got %b want %b", e, col, pat[k%4]); end
        end
        n_cmp++; if (vcnt !== 0) begin n_err++; $display("FAIL idle_valid_count: got %0d want 0", vcnt); end
        n_cmp++; if (key_pressed !== 1'b0) begin n_err++; $display("FAIL idle_pressed: got %b want 0", key_pressed); end
    endtask

    task automatic test_bounce();
        vcnt = 0;
        set_keys(16'h0010);
        run_to(44);
        set_keys(16'h0000);
        run_to(47);
        n_cmp++; if (col !== 4'b1110) begin n_err++; $display("FAIL bounce_col_held: got %b want 1110", col); end
        run_to(48);
        n_cmp++; if (col !== 4'b1101) begin n_err++; $display("FAIL bounce_col_resume: got %b want 1101", col); end
        n_cmp++; if (vcnt !== 0) begin n_err++; $display("FAIL bounce_valid_count: got %0d want 0", vcnt); end
        n_cmp++; if (key_code !== 4'd0) begin n_err++; $display("FAIL bounce_code: got %0d want 0", key_code); end
        n_cmp++; if (key_pressed !== 1'b0) begin n_err++; $display("FAIL bounce_pressed: got %b want 0", key_pressed); end
    endtask

    task automatic test_press_release();
        vcnt = 0;
        set_keys(16'h0200);
        run_to(63);
        n_cmp++; if (vcnt !== 0 || key_pressed !== 1'b0) begin n_err++; $display("FAIL press_early: got vcnt=%0d pressed=%b want 0/0", vcnt, key_pressed); end
        run_to(64);
        n_cmp++; if (key_valid !== 1'b1) begin n_err++; $display("FAIL press_valid: got %b want 1", key_valid); end
        n_cmp++; if (key_code !== 4'd9) begin n_err++; $display("FAIL press_code: got %0d want 9", key_code); end
        n_cmp++; if (key_pressed !== 1'b1) begin n_err++; $display("FAIL press_pressed: got %b want 1", key_pressed); end
        run_to(65);
        n_cmp++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL press_pulse_width: got %b want 0", key_valid); end
        run_to(72);
        set_keys(16'h0000);
        run_to(83);
        n_cmp++; if (key_pressed !== 1'b1 || col !== 4'b1101) begin n_err++; $display("FAIL release_early: got pressed=%b col=%b want 1/1101", key_pressed, col); end
        run_to(84);
        n_cmp++; if (key_pressed !== 1'b0) begin n_err++; $display("FAIL release_pressed: got %b want 0", key_pressed); end
        n_cmp++; if (col !== 4'b1011) begin n_err++; $display("FAIL release_col: got %b want 1011", col); end
        n_cmp++; if (key_code !== 4'd9) begin n_err++; $display("FAIL release_code_kept: got %0d want 9", key_code); end
        n_cmp++; if (vcnt !== 1) begin n_err++; $display("FAIL press_valid_count: got %0d want 1", vcnt); end
    endtask

    task automatic test_priority();
        vcnt = 0;
        set_keys(16'h0880);
        run_to(88);
        n_cmp++; if (col !== 4'b0111) begin n_err++; $display("FAIL prio_col: got %b want 0111", col); end
        run_to(104);
        n_cmp++; if (key_valid !== 1'b1 || key_code !== 4'd7) begin n_err++; $display("FAIL prio_accept: got valid=%b code=%0d want 1/7", key_valid, key_code); end
        run_to(108);
        set_keys(16'h0000);
        run_to(120);
        n_cmp++; if (key_pressed !== 1'b0 || col !== 4'b1110) begin n_err++; $display("FAIL prio_release: got pressed=%b col=%b want 0/1110", key_pressed, col); end
        n_cmp++; if (vcnt !== 1) begin n_err++; $display("FAIL prio_valid_count: got %0d want 1", vcnt); end
    endtask

    task automatic test_held_second_key();
        set_keys(16'h0001);
        run_to(136);
        n_cmp++; if (key_valid !== 1'b1 || key_code !== 4'd0) begin n_err++; $display("FAIL held_first: got valid=%b code=%0d want 1/0", key_valid, key_code); end
        vcnt = 0;
        run_to(140);
        set_keys(16'h1001);
        run_to(148);
        n_cmp++; if (key_pressed !== 1'b1 || col !== 4'b1110) begin n_err++; $display("FAIL held_hold: got pressed=%b col=%b want 1/1110", key_pressed, col); end
        set_keys(16'h1000);
        run_to(159);
        n_cmp++; if (key_pressed !== 1'b1) begin n_err++; $display("FAIL held_release_early: got %b want 1", key_pressed); end
        run_to(160);
        n_cmp++; if (key_pressed !== 1'b0 || col !== 4'b1101) begin n_err++; $display("FAIL held_release: got pressed=%b col=%b want 0/1101", key_pressed, col); end
        run_to(187);
        n_cmp++; if (vcnt !== 0 || key_pressed !== 1'b0) begin n_err++; $display("FAIL held_no_second: got vcnt=%0d pressed=%b want 0/0", vcnt, key_pressed); end
        run_to(188);
        n_cmp++; if (key_valid !== 1'b1 || key_code !== 4'd12 || key_pressed !== 1'b1) begin n_err++; $display("FAIL held_second_accept: got valid=%b code=%0d pressed=%b want 1/12/1", key_valid, key_code, key_pressed); end
        run_to(189);
        n_cmp++; if (vcnt !== 1) begin n_err++; $display("FAIL held_second_count: got %0d want 1", vcnt); end
    endtask

    task automatic test_async_reset();
        run_to(192);
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (col !== 4'b1110) begin n_err++; $display("FAIL areset_col: got %b want 1110", col); end
        n_cmp++; if (key_pressed !== 1'b0) begin n_err++; $display("FAIL areset_pressed: got %b want 0", key_pressed); end
        n_cmp++; if (key_code !== 4'd0) begin n_err++; $display("FAIL areset_code: got %0d want 0", key_code); end
        n_cmp++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL areset_valid: got %b want 0", key_valid); end
        cyc();
        cyc();
        release_reset();
        run_to(15);
        n_cmp++; if (vcnt !== 0 || key_pressed !== 1'b0) begin n_err++; $display("FAIL areset_no_early_valid: got vcnt=%0d pressed=%b want 0/0", vcnt, key_pressed); end
        run_to(16);
        n_cmp++; if (key_valid !== 1'b1 || key_code !== 4'd12) begin n_err++; $display("FAIL areset_redebounce: got valid=%b code=%0d want 1/12", key_valid, key_code); end
    endtask

    initial begin
        test_reset();
        test_idle_scan();
        test_bounce();
        test_press_release();
        test_priority();
        test_held_second_key();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached, want finish before 50000");
        $fatal(1);
    end

endmodule
